// File: rtl/vending_machine_param.sv
// vending_machine_param
// Parametrised vending-machine controller. It keeps all money in 5rs units
// and accepts 5rs and 10rs coins, rejecting any coin that would overflow the
// credit register. It supports N one-hot item selections with a per-item
// price table, plus cancel/refund, and returns change serially as one 5rs
// coin per cycle.
module vending_machine_param #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 4,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_TABLE = {4'd6, 4'd5, 4'd4, 4'd3},
    localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_ITEMS-1:0] item_sel,
    input  logic                 five_in,
    input  logic                 ten_in,
    input  logic                 cancel,
    output logic                 dispense,
    output logic [IDX_W-1:0]     item_out,
    output logic                 five_out,
    output logic                 coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy
);

    localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CREDIT_W-1:0]   r_credit;
    logic [CREDIT_W-1:0]   w_credit_nxt;
    logic [CREDIT_W-1:0]   r_change;
    logic [CREDIT_W-1:0]   w_change_nxt;
    logic [IDX_W-1:0]      r_item;
    logic [IDX_W-1:0]      w_item_nxt;
    logic                  r_coin_reject;
    logic                  w_coin_reject_nxt;

    // Coin and selection decode signals
    logic [1:0]            w_coin_val;
    logic                  w_coin_present;
    logic [CREDIT_W:0]     w_coin_sum;
    logic                  w_coin_fits;
    logic                  w_sel_onehot;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [CREDIT_W-1:0]   w_sel_price;
    logic                  w_sel_valid;
    logic                  w_sel_afford;

    // Coin value in 5rs units; both coins at once is treated as no value
    always_comb begin
        w_coin_present = five_in | ten_in;
        w_coin_val     = 2'd0;
        if (five_in && !ten_in) begin
            w_coin_val = 2'd1;
        end else if (ten_in && !five_in) begin
            w_coin_val = 2'd2;
        end
        // One extra bit so an overflowing sum is visible before truncation
        w_coin_sum  = {1'b0, r_credit} + {{(CREDIT_W-1){1'b0}}, w_coin_val};
        w_coin_fits = (w_coin_val != 2'd0) && (w_coin_sum <= MAX_CREDIT);
    end

    // Selection decode: index and price of the selected item, valid only if one-hot and priced
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_sel_idx   = '0;
        w_sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel[i]) begin
                w_sel_idx   = IDX_W'(i);
                w_sel_price = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
            end
        end
        w_sel_onehot = $onehot(item_sel);
        w_sel_valid  = w_sel_onehot && (w_sel_price != '0);
        w_sel_afford = w_sel_valid && (r_credit >= w_sel_price);
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_change      <= '0;
            r_item        <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_change      <= w_change_nxt;
            r_item        <= w_item_nxt;
            r_coin_reject <= w_coin_reject_nxt;
        end
    end

    // Next-state and datapath update; any coin present is rejected unless a branch accepts it
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_change_nxt      = r_change;
        w_item_nxt        = r_item;
        w_coin_reject_nxt = w_coin_present;

        case (r_state)
            S_IDLE: begin
                // Cancel and selections are meaningless with no credit
                if (w_coin_fits) begin
                    w_credit_nxt      = w_coin_sum[CREDIT_W-1:0];
                    w_coin_reject_nxt = 1'b0;
                    w_state_nxt       = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    w_change_nxt = r_credit;
                    w_credit_nxt = '0;
                    w_state_nxt  = (r_credit != '0) ? S_CHANGE : S_IDLE;
                end else if (w_sel_afford) begin
                    // Uses registered credit: a coin on this edge is rejected, not counted
                    w_item_nxt   = w_sel_idx;
                    w_change_nxt = r_credit - w_sel_price;
                    w_credit_nxt = '0;
                    w_state_nxt  = S_VEND;
                end else if (w_coin_fits) begin
                    w_credit_nxt      = w_coin_sum[CREDIT_W-1:0];
                    w_coin_reject_nxt = 1'b0;
                end
            end

            S_VEND: begin
                w_state_nxt = (r_change != '0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                // One 5rs coin leaves per cycle; the last one returns us to IDLE
                if (r_change <= CREDIT_W'(1)) begin
                    w_change_nxt = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_change_nxt = r_change - CREDIT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state; registered values passed straight through
    always_comb begin
        dispense    = (r_state == S_VEND);
        five_out    = (r_state == S_CHANGE);
        busy        = (r_state == S_VEND) || (r_state == S_CHANGE);
        item_out    = r_item;
        coin_reject = r_coin_reject;
        credit      = r_credit;
    end

endmodule
